// File: rtl/opl_seq_pkg.sv
// Shared types and helpers for the multi-chip OPL write sequencer.
package opl_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR_STB,
      ST_ADDR_HOLD,
      ST_DATA_STB,
      ST_DATA_HOLD,
      ST_RECOVER
   } seq_state_t;

   localparam logic [1:0] SEL_INDEX = 2'd0;
   localparam logic [1:0] SEL_DATA  = 2'd1;
   localparam logic [1:0] SEL_FLUSH = 2'd2;

   // chan is sized for the largest supported chip count (4)
   typedef struct packed {
      logic [1:0] chan;
      logic [7:0] index;
      logic [7:0] data;
   } entry_t;

   function automatic int chan_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/opl_write_sequencer_if.sv
// Decoded-bus input and chip-side output bundle of the OPL write sequencer.
interface opl_write_sequencer_if
   import opl_seq_pkg::*;
#(
   parameter int CHANNELS   = 2,
   parameter int DEPTH_LOG2 = 8
);
   localparam int CW = chan_w(CHANNELS);

   logic                  bus_valid;
   logic [1:0]            bus_sel;
   logic [CW-1:0]         bus_chan;
   logic [7:0]            bus_data;

   logic [CHANNELS-1:0]   hw_cs_n;
   logic                  hw_wr_n;
   logic                  hw_a0;
   logic [7:0]            hw_din;
   logic [DEPTH_LOG2:0]   level;
   logic                  overflow;
   logic                  busy;

   modport master (
      output bus_valid, bus_sel, bus_chan, bus_data,
      input  hw_cs_n, hw_wr_n, hw_a0, hw_din, level, overflow, busy
   );

   modport slave (
      input  bus_valid, bus_sel, bus_chan, bus_data,
      output hw_cs_n, hw_wr_n, hw_a0, hw_din, level, overflow, busy
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, synchronous clear and pop-while-full push.
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      wr_data,
   output logic [WIDTH-1:0]      rd_data,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  full,
   output logic                  empty
);
   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
   localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;
   localparam logic [DEPTH_LOG2:0]   LVL_FULL = DEPTH;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (level == LVL_FULL);
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !clr)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (do_push && !do_pop)
            level <= level + LVL_ONE;
         else if (!do_push && do_pop)
            level <= level - LVL_ONE;
      end
   end

endmodule

// File: rtl/opl_write_sequencer.sv
// Buffers decoded PIX register writes and replays them to up to four OPL chips
// with programmable strobe, address-hold, data-hold and recovery timing.
//
// state      | meaning
// -----------+----------------------------------------------------
// IDLE       | waiting for a queued entry; pops the head when present
// ADDR_STB   | cs/a0=0/index driven, wr_n low for PULSE cycles
// ADDR_HOLD  | wr_n high, index held for ADDR_WAIT cycles
// DATA_STB   | a0=1/data driven, wr_n low for PULSE cycles
// DATA_HOLD  | wr_n high, data held for DATA_WAIT cycles
// RECOVER    | chip deselected for POST_WAIT cycles
module opl_write_sequencer
   import opl_seq_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8,
   parameter int CHANNELS   = 2,
   parameter int PULSE      = 1,
   parameter int ADDR_WAIT  = 12,
   parameter int DATA_WAIT  = 30,
   parameter int POST_WAIT  = 200
) (
   input logic                    clk,
   input logic                    rst,
   opl_write_sequencer_if.slave   bus
);
   localparam int CW    = chan_w(CHANNELS);
   localparam int CNT_W = $clog2(max4(PULSE, ADDR_WAIT, DATA_WAIT, POST_WAIT)) + 1;
   localparam int EW    = $bits(entry_t);

   localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE - 1);
   localparam logic [CNT_W-1:0] LD_ADDR  = CNT_W'(ADDR_WAIT - 1);
   localparam logic [CNT_W-1:0] LD_DATA  = CNT_W'(DATA_WAIT - 1);
   localparam logic [CNT_W-1:0] LD_POST  = CNT_W'(POST_WAIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;

   seq_state_t            state;
   logic [CNT_W-1:0]      cnt;
   logic [7:0]            index_q [2**CW];
   logic [7:0]            data_q;
   logic [CHANNELS-1:0]   cs_n_q;
   logic                  wr_n_q;
   logic                  a0_q;
   logic [7:0]            din_q;
   logic                  ovf_q;

   logic [2:0]            chan_ext;
   logic                  chan_ok;
   logic                  is_index;
   logic                  is_data;
   logic                  is_flush;
   logic                  pop;
   entry_t                push_entry;
   entry_t                head;
   logic [EW-1:0]         fifo_rd;
   logic [DEPTH_LOG2:0]   fifo_level;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [3:0]            chan_mask;

   assign chan_ext   = 3'(bus.bus_chan);
   assign chan_ok    = (chan_ext < 3'(CHANNELS));
   assign is_index   = bus.bus_valid && (bus.bus_sel == SEL_INDEX) && chan_ok;
   assign is_data    = bus.bus_valid && (bus.bus_sel == SEL_DATA) && chan_ok;
   assign is_flush   = bus.bus_valid && (bus.bus_sel == SEL_FLUSH);
   assign pop        = (state == ST_IDLE) && !fifo_empty && !is_flush;

   assign push_entry = '{chan: 2'(bus.bus_chan), index: index_q[bus.bus_chan], data: bus.bus_data};
   assign head       = entry_t'(fifo_rd);
   assign chan_mask  = 4'b0001 << head.chan;

   sync_fifo #(
      .WIDTH      (EW),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr     (is_flush),
      .push    (is_data),
      .pop     (pop),
      .wr_data (push_entry),
      .rd_data (fifo_rd),
      .level   (fifo_level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // index registers survive a flush; only reset clears them
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**CW; i++)
            index_q[i] <= '0;
      end else if (is_index) begin
         index_q[bus.bus_chan] <= bus.bus_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || is_flush)
         ovf_q <= 1'b0;
      else if (is_data && fifo_full && !pop)
         ovf_q <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || is_flush) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         data_q <= '0;
         cs_n_q <= '1;
         wr_n_q <= 1'b1;
         a0_q   <= 1'b0;
         din_q  <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state  <= ST_ADDR_STB;
                  cnt    <= LD_PULSE;
                  data_q <= head.data;
                  cs_n_q <= ~chan_mask[CHANNELS-1:0];
                  a0_q   <= 1'b0;
                  din_q  <= head.index;
                  wr_n_q <= 1'b0;
               end
            end
            ST_ADDR_STB: begin
               if (cnt == '0) begin
                  state  <= ST_ADDR_HOLD;
                  cnt    <= LD_ADDR;
                  wr_n_q <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            ST_ADDR_HOLD: begin
               if (cnt == '0) begin
                  state  <= ST_DATA_STB;
                  cnt    <= LD_PULSE;
                  a0_q   <= 1'b1;
                  din_q  <= data_q;
                  wr_n_q <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            ST_DATA_STB: begin
               if (cnt == '0) begin
                  state  <= ST_DATA_HOLD;
                  cnt    <= LD_DATA;
                  wr_n_q <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            ST_DATA_HOLD: begin
               if (cnt == '0) begin
                  state  <= ST_RECOVER;
                  cnt    <= LD_POST;
                  cs_n_q <= '1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            ST_RECOVER: begin
               if (cnt == '0)
                  state <= ST_IDLE;
               else
                  cnt <= cnt - CNT_ONE;
            end
            default: begin
               state  <= ST_IDLE;
               cs_n_q <= '1;
               wr_n_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.hw_cs_n  = cs_n_q;
   assign bus.hw_wr_n  = wr_n_q;
   assign bus.hw_a0    = a0_q;
   assign bus.hw_din   = din_q;
   assign bus.level    = fifo_level;
   assign bus.overflow = ovf_q;
   assign bus.busy     = (fifo_level != '0) || (state != ST_IDLE);

endmodule

// File: tb/tb_opl_write_sequencer.sv
// Scoreboard bench: expected writes queued as they are pushed, checked against chip strobes.
module tb_opl_write_sequencer;
   import opl_seq_pkg::*;

   localparam int DEPTH_LOG2 = 4;
   localparam int DEPTH      = 2 ** DEPTH_LOG2;
   localparam int CHANNELS   = 2;
   localparam int PULSE      = 1;
   localparam int ADDR_WAIT  = 12;
   localparam int DATA_WAIT  = 30;
   localparam int POST_WAIT  = 200;
   localparam int PERIOD     = 1 + 2 * PULSE + ADDR_WAIT + DATA_WAIT + POST_WAIT;

   typedef struct {
      int         chan;
      logic [7:0] idx;
      logic [7:0] dat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   opl_write_sequencer_if #(.CHANNELS(CHANNELS), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

   opl_write_sequencer #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .CHANNELS   (CHANNELS),
      .PULSE      (PULSE),
      .ADDR_WAIT  (ADDR_WAIT),
      .DATA_WAIT  (DATA_WAIT),
      .POST_WAIT  (POST_WAIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   n_total = 0;
   int   n_bad   = 0;
   int   cyc     = 0;
   exp_t exp_q[$];
   logic [7:0] tb_index [CHANNELS];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int want);
      n_total++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s got=0x%0h want=0x%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic int chan_of(input logic [1:0] cs);
      case (cs)
         2'b10:   return 0;
         2'b01:   return 1;
         default: return 9;
      endcase
   endfunction

   // monitor: reconstruct chip transactions from strobes
   int         n_stb = 0;
   logic       wr_prev = 1'b1;
   int         low_cnt = 0;
   bit         in_txn = 0;
   bit         have_prev = 0;
   int         t_prev = 0;
   int         t_addr = 0;
   int         m_chan = 0;
   logic [7:0] m_idx = 0;

   always @(negedge clk) begin
      if (rst) begin
         in_txn    = 0;
         have_prev = 0;
         wr_prev   = 1'b1;
         low_cnt   = 0;
      end else begin
         if (!bus.busy) have_prev = 0;
         if (wr_prev && !bus.hw_wr_n) begin
            if (!bus.hw_a0) begin
               n_stb++;
               if (have_prev)
                  chk("entry_gap", (cyc - t_prev >= PERIOD) ? PERIOD : cyc - t_prev, PERIOD);
               have_prev = 1;
               t_prev    = cyc;
               t_addr    = cyc;
               in_txn    = 1;
               m_chan    = chan_of(bus.hw_cs_n);
               m_idx     = bus.hw_din;
            end else begin
               exp_t e;
               chk("data_after_addr", int'(in_txn), 1);
               chk("addr_to_data", cyc - t_addr, PULSE + ADDR_WAIT);
               chk("cs_stable", chan_of(bus.hw_cs_n), m_chan);
               if (exp_q.size() == 0) begin
                  chk("unexpected_txn", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("txn_chan", m_chan, e.chan);
                  chk("txn_index", m_idx, e.idx);
                  chk("txn_data", bus.hw_din, e.dat);
               end
               in_txn = 0;
            end
         end
         if (!bus.hw_wr_n) begin
            low_cnt++;
         end else begin
            if (!wr_prev) chk("strobe_width", low_cnt, PULSE);
            low_cnt = 0;
         end
         wr_prev = bus.hw_wr_n;
      end
   end

   task automatic bus_write(input logic [1:0] sel, input int chan, input logic [7:0] d);
      @(negedge clk);
      bus.bus_valid = 1'b1;
      bus.bus_sel   = sel;
      bus.bus_chan  = chan[0];
      bus.bus_data  = d;
      @(posedge clk);
      #1;
      bus.bus_valid = 1'b0;
   endtask

   task automatic set_index(input int chan, input logic [7:0] v);
      tb_index[chan] = v;
      bus_write(SEL_INDEX, chan, v);
   endtask

   task automatic push(input int chan, input logic [7:0] d, input bit accept);
      if (accept) exp_q.push_back('{chan: chan, idx: tb_index[chan], dat: d});
      bus_write(SEL_DATA, chan, d);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.busy && n < budget);
      chk({tag, "_timeout"}, int'(bus.busy), 0);
      chk({tag, "_sb_left"}, exp_q.size(), 0);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_cs_n"}, bus.hw_cs_n, 2'b11);
      chk({tag, "_wr_n"}, bus.hw_wr_n, 1);
      chk({tag, "_level"}, bus.level, 0);
      chk({tag, "_overflow"}, bus.overflow, 0);
      chk({tag, "_busy"}, bus.busy, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int snap;
      bus.bus_valid = 1'b0;
      bus.bus_sel   = 2'd0;
      bus.bus_chan  = '0;
      bus.bus_data  = 8'h00;
      for (int i = 0; i < CHANNELS; i++) tb_index[i] = 8'h00;

      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      chk("reset_a0", bus.hw_a0, 0);
      chk("reset_din", bus.hw_din, 0);
      rst = 1'b0;

      // single write, then a second queued behind it (push and pop in one cycle)
      set_index(0, 8'h20);
      push(0, 8'h01, 1);
      chk("t1_level_after_push", bus.level, 1);
      push(0, 8'h02, 1);
      chk("push_pop_level", bus.level, 1);
      chk("t1_wr_n", bus.hw_wr_n, 0);
      chk("t1_cs_n", bus.hw_cs_n, 2'b10);
      chk("t1_a0", bus.hw_a0, 0);
      chk("t1_din", bus.hw_din, 8'h20);
      chk("t1_busy", bus.busy, 1);
      wait_idle("t1", 1000);

      // interleaved channels, each with its own latched index
      set_index(0, 8'h40);
      set_index(1, 8'h41);
      push(0, 8'hA0, 1);
      push(1, 8'hA1, 1);
      push(0, 8'hA2, 1);
      set_index(1, 8'h55);
      push(1, 8'hA3, 1);
      wait_idle("ilv", 2000);

      // overflow: DEPTH+3 back-to-back pushes, DEPTH+1 survive
      set_index(0, 8'h60);
      for (int i = 0; i < DEPTH + 3; i++)
         push(0, 8'(8'h80 + i), i < DEPTH + 1);
      chk("ovf_level_full", bus.level, DEPTH);
      chk("ovf_flag", bus.overflow, 1);
      wait_idle("ovf", (DEPTH + 3) * PERIOD);
      chk("ovf_sticky", bus.overflow, 1);

      // flush during the data strobe
      set_index(1, 8'h33);
      push(1, 8'hB0, 1);
      push(1, 8'hB1, 1);
      push(1, 8'hB2, 1);
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         if (!bus.hw_wr_n && bus.hw_a0) break;
         n++;
      end
      chk("flush_reach_data_stb", int'(n < 100), 1);
      bus.bus_valid = 1'b1;
      bus.bus_sel   = SEL_FLUSH;
      @(posedge clk);
      #1;
      bus.bus_valid = 1'b0;
      chk_idle_outputs("flush");
      exp_q.delete();
      push(1, 8'hB3, 1);
      wait_idle("post_flush", 1000);

      // reset during ADDR_HOLD with five entries queued
      set_index(0, 8'h10);
      for (int i = 0; i < 6; i++) push(0, 8'(8'hC0 + i), 1);
      chk("rst_level_queued", bus.level, 5);
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (bus.hw_wr_n && !bus.hw_a0 && bus.hw_cs_n == 2'b10) break;
         n++;
      end
      chk("rst_reach_addr_hold", int'(n < 50), 1);
      rst = 1'b1;
      @(negedge clk);
      chk_idle_outputs("midrst");
      chk("midrst_a0", bus.hw_a0, 0);
      chk("midrst_din", bus.hw_din, 0);
      rst = 1'b0;
      exp_q.delete();
      for (int i = 0; i < CHANNELS; i++) tb_index[i] = 8'h00;
      snap = n_stb;
      repeat (300) @(negedge clk);
      chk("no_strobe_after_rst", n_stb - snap, 0);
      chk("level_after_rst", bus.level, 0);
      push(1, 8'h77, 1);
      wait_idle("post_rst", 1000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
